// File: rtl/ccff_chain_programmer_pkg.sv
// Shared types and parameter-derived sizing helpers for the CCFF chain programmer.
package ccff_prog_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic int calc_nwords(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

    // Bits carried by the final word; equals word_w when the chain is a whole number of words.
    function automatic int calc_last_bits(input int chain_len, input int word_w);
        return chain_len - (calc_nwords(chain_len, word_w) - 1) * word_w;
    endfunction

    function automatic int calc_cnt_w(input int max_count);
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/ccff_chain_programmer_if.sv
// Configuration-controller side of the programmer: start/word handshake, status and readback.
interface ccff_chain_programmer_if #(
    parameter int WORD_W = 8
);
    logic              cfg_start;
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;
    logic              cfg_busy;
    logic              cfg_done;
    logic [WORD_W-1:0] rb_data;
    logic              rb_valid;

    modport master (
        output cfg_start, cfg_data, cfg_valid,
        input  cfg_ready, cfg_busy, cfg_done, rb_data, rb_valid
    );

    modport slave (
        input  cfg_start, cfg_data, cfg_valid,
        output cfg_ready, cfg_busy, cfg_done, rb_data, rb_valid
    );
endinterface

// File: rtl/ccff_chain_programmer_serializer.sv
// Parallel-load MSB-first shift register with a per-word bit budget; shorter words are
// left-aligned on load so the first valid bit is always at the MSB.
module ccff_bit_serializer #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [WORD_W-1:0] data_i,
    input  logic [CNT_W-1:0]  nbits_i,
    input  logic              shift_i,
    input  logic              serial_i,
    output logic              msb_o,
    output logic [WORD_W-1:0] word_o,
    output logic              last_bit_o
);
    localparam logic [CNT_W-1:0] WORD_W_C = CNT_W'(WORD_W);

    logic [WORD_W-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Value the register takes after one more shift; doubles as the captured readback word.
    assign word_o     = (sr_q << 1) | WORD_W'(serial_i);
    assign msb_o      = sr_q[WORD_W-1];
    assign last_bit_o = (cnt_q == CNT_W'(1));

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (load_i) begin
            sr_d  = data_i << (WORD_W_C - nbits_i);
            cnt_d = nbits_i;
        end else if (shift_i && (cnt_q != '0)) begin
            sr_d  = word_o;
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/ccff_chain_programmer.sv
// Serialises bitstream words MSB-first into a CCFF chain, exactly CHAIN_LEN shifts per pass.
// Optional macro CCFF_READBACK_EN captures the chain tail into readback words.
module ccff_chain_programmer
    import ccff_prog_pkg::*;
#(
    parameter int CHAIN_LEN = 33,
    parameter int WORD_W    = 8
) (
    input  logic                     prog_clk,
    input  logic                     prog_reset_n,
    ccff_chain_programmer_if.slave   cfg,
    output logic                     ccff_head,
    output logic                     ccff_shift_en,
    input  logic                     ccff_tail
);
    localparam int NWORDS    = calc_nwords(CHAIN_LEN, WORD_W);
    localparam int LAST_BITS = calc_last_bits(CHAIN_LEN, WORD_W);
    localparam int CNT_W     = calc_cnt_w(CHAIN_LEN);
    localparam int WCNT_W    = calc_cnt_w(NWORDS);
    localparam int SER_W     = calc_cnt_w(WORD_W);

    localparam logic [CNT_W-1:0]  CHAIN_LEN_C = CNT_W'(CHAIN_LEN);
    localparam logic [WCNT_W-1:0] LAST_WORD_C = WCNT_W'(NWORDS - 1);

    state_e              state_q;
    logic [CNT_W-1:0]    bit_cnt_q;
    logic [WCNT_W-1:0]   word_cnt_q;
    logic                cfg_ready_q;
    logic                shift_en_q;
    logic                busy_q;
    logic                done_q;

    logic                handshake;
    logic [SER_W-1:0]    word_nbits;
    logic                wr_msb;
    logic                wr_last;
    logic [WORD_W-1:0]   wr_word_unused;

    assign handshake  = cfg_ready_q & cfg.cfg_valid;
    assign word_nbits = (word_cnt_q == LAST_WORD_C) ? SER_W'(LAST_BITS) : SER_W'(WORD_W);

    // The write register drains to zero after its last bit, so its MSB is already 0 between words.
    ccff_bit_serializer #(.WORD_W(WORD_W), .CNT_W(SER_W)) u_wr_ser (
        .clk        (prog_clk),
        .rst_n      (prog_reset_n),
        .load_i     (handshake),
        .data_i     (cfg.cfg_data),
        .nbits_i    (word_nbits),
        .shift_i    (shift_en_q),
        .serial_i   (1'b0),
        .msb_o      (wr_msb),
        .word_o     (wr_word_unused),
        .last_bit_o (wr_last)
    );

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            word_cnt_q  <= '0;
            cfg_ready_q <= 1'b0;
            shift_en_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cfg.cfg_start) begin
                        bit_cnt_q   <= '0;
                        word_cnt_q  <= '0;
                        cfg_ready_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (cfg.cfg_valid) begin
                        word_cnt_q  <= word_cnt_q + WCNT_W'(1);
                        cfg_ready_q <= 1'b0;
                        shift_en_q  <= 1'b1;
                        state_q     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                    if (wr_last) begin
                        shift_en_q <= 1'b0;
                        if (bit_cnt_q + CNT_W'(1) == CHAIN_LEN_C) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            cfg_ready_q <= 1'b1;
                            state_q     <= ST_LOAD;
                        end
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ccff_head     = wr_msb;
    assign ccff_shift_en = shift_en_q;
    assign cfg.cfg_ready = cfg_ready_q;
    assign cfg.cfg_busy  = busy_q;
    assign cfg.cfg_done  = done_q;

`ifdef CCFF_READBACK_EN
    logic              rb_msb_unused;
    logic [WORD_W-1:0] rb_word;
    logic              rb_last;
    logic [WORD_W-1:0] rb_data_q;
    logic              rb_valid_q;

    // Loaded with zeros using the same bit budget, so a short final word comes out right-aligned.
    ccff_bit_serializer #(.WORD_W(WORD_W), .CNT_W(SER_W)) u_rb_ser (
        .clk        (prog_clk),
        .rst_n      (prog_reset_n),
        .load_i     (handshake),
        .data_i     ('0),
        .nbits_i    (word_nbits),
        .shift_i    (shift_en_q),
        .serial_i   (ccff_tail),
        .msb_o      (rb_msb_unused),
        .word_o     (rb_word),
        .last_bit_o (rb_last)
    );

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            rb_data_q  <= '0;
            rb_valid_q <= 1'b0;
        end else begin
            rb_valid_q <= shift_en_q & rb_last;
            if (shift_en_q && rb_last) begin
                rb_data_q <= rb_word;
            end
        end
    end

    assign cfg.rb_data  = rb_data_q;
    assign cfg.rb_valid = rb_valid_q;
`else
    logic tail_unused;
    assign tail_unused  = ccff_tail;
    assign cfg.rb_data  = '0;
    assign cfg.rb_valid = 1'b0;
`endif
endmodule

// File: tb/tb_ccff_chain_programmer.sv
// Directed bench: 33-stage and 8-stage chain models driven by two programmer instances.
module tb_ccff_chain_programmer;
    logic prog_clk;
    logic prog_reset_n;

    ccff_chain_programmer_if #(.WORD_W(8)) cif ();
    ccff_chain_programmer_if #(.WORD_W(8)) cif8 ();

    logic ccff_head, ccff_shift_en, ccff_tail;
    logic head8, sh8, tail8;

    logic [32:0] chain;
    logic [7:0]  chain8;
    logic        preload;

    ccff_chain_programmer #(.CHAIN_LEN(33), .WORD_W(8)) dut (
        .prog_clk      (prog_clk),
        .prog_reset_n  (prog_reset_n),
        .cfg           (cif),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .ccff_tail     (ccff_tail)
    );

    ccff_chain_programmer #(.CHAIN_LEN(8), .WORD_W(8)) dut8 (
        .prog_clk      (prog_clk),
        .prog_reset_n  (prog_reset_n),
        .cfg           (cif8),
        .ccff_head     (head8),
        .ccff_shift_en (sh8),
        .ccff_tail     (tail8)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    // Chain models: stage 0 nearest the head, tail is the highest stage.
    always @(posedge prog_clk) begin
        if (preload) begin
            chain  <= '1;
            chain8 <= '0;
        end else begin
            if (ccff_shift_en) chain  <= {chain[31:0], ccff_head};
            if (sh8)           chain8 <= {chain8[6:0], head8};
        end
    end
    assign ccff_tail = chain[32];
    assign tail8     = chain8[7];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [7:0]  words [5];
    logic [32:0] exp_chain;

    int hs_cyc [5];
    int n_hs, n_shift, done_cyc, busy_bad, gap_bad;
    int rb_n;
    logic [7:0] rb_vals [8];
    int rb_cyc [8];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One pass on the 33-stage DUT; cycle 0 is the cfg_start cycle.
    task automatic run_pass(input int gap_word, input int gap_len, input int start_pulse_cyc,
                            input int rst_cyc);
        int gap_left;
        n_hs = 0; n_shift = 0; done_cyc = -1; busy_bad = 0; gap_bad = 0; rb_n = 0;
        gap_left = gap_len;
        for (int cyc = 0; cyc < 150 && done_cyc < 0; cyc++) begin
            @(posedge prog_clk); #1;
            cif.cfg_start = (cyc == 0) || (cyc == start_pulse_cyc);
            if (cyc == rst_cyc) begin
                prog_reset_n = 1'b0;
                #1;
                check("rst_mid_shift_en", ccff_shift_en, 0);
                check("rst_mid_head",     ccff_head, 0);
                check("rst_mid_ready",    cif.cfg_ready, 0);
                check("rst_mid_busy",     cif.cfg_busy, 0);
                check("rst_mid_done",     cif.cfg_done, 0);
                cif.cfg_start = 1'b0;
                cif.cfg_valid = 1'b0;
                return;
            end
            if (ccff_shift_en) n_shift++;
            if (cif.cfg_done) done_cyc = cyc;
            if (cyc >= 1 && !cif.cfg_busy) busy_bad++;
            if (cif.rb_valid && rb_n < 8) begin
                rb_vals[rb_n] = cif.rb_data;
                rb_cyc[rb_n]  = cyc;
                rb_n++;
            end
            if (cif.cfg_ready && n_hs == gap_word && gap_left > 0) begin
                cif.cfg_valid = 1'b0;
                gap_left--;
                if (ccff_shift_en) gap_bad++;
            end else begin
                cif.cfg_valid = 1'b1;
                cif.cfg_data  = words[(n_hs < 5) ? n_hs : 0];
            end
            if (cif.cfg_ready && cif.cfg_valid) begin
                if (n_hs < 5) hs_cyc[n_hs] = cyc;
                n_hs++;
            end
        end
        @(posedge prog_clk); #1;
        cif.cfg_valid = 1'b0;
        check("post_busy_low", cif.cfg_busy, 0);
        check("post_done_low", cif.cfg_done, 0);
    endtask

    initial begin
        int idle_bad;
        int hs8, n_shift8, done8;

        words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF; words[3] = 8'h00; words[4] = 8'h01;
        exp_chain = {8'hA5, 8'h3C, 8'hFF, 8'h00, 1'b1};

        prog_reset_n   = 1'b0;
        preload        = 1'b1;
        cif.cfg_start  = 1'b0; cif.cfg_valid  = 1'b0; cif.cfg_data  = '0;
        cif8.cfg_start = 1'b0; cif8.cfg_valid = 1'b0; cif8.cfg_data = '0;
        repeat (3) @(posedge prog_clk);
        #1;
        check("reset_ready",    cif.cfg_ready, 0);
        check("reset_head",     ccff_head, 0);
        check("reset_shift_en", ccff_shift_en, 0);
        check("reset_busy",     cif.cfg_busy, 0);
        check("reset_done",     cif.cfg_done, 0);
        check("reset_rb_valid", cif.rb_valid, 0);
        check("reset_rb_data",  cif.rb_data, 0);
        prog_reset_n = 1'b1;
        preload      = 1'b0;

        // cfg_valid in IDLE must not produce a handshake or any activity
        idle_bad = 0;
        cif.cfg_valid = 1'b1;
        cif.cfg_data  = 8'h5A;
        repeat (4) begin
            @(posedge prog_clk); #1;
            if (cif.cfg_ready || ccff_shift_en || cif.cfg_busy) idle_bad++;
        end
        check("idle_valid_ignored", idle_bad, 0);

        // Pass A: baseline, chain preloaded with all-ones
        run_pass(99, 0, -1, -1);
        check("A_hs0", hs_cyc[0], 1);
        check("A_hs1", hs_cyc[1], 10);
        check("A_hs2", hs_cyc[2], 19);
        check("A_hs3", hs_cyc[3], 28);
        check("A_hs4", hs_cyc[4], 37);
        check("A_n_hs", n_hs, 5);
        check("A_shifts", n_shift, 33);
        check("A_done_cyc", done_cyc, 39);
        check("A_busy_span", busy_bad, 0);
        check("A_chain", chain, exp_chain);
        check("A_stage32", chain[32], 1);
        check("A_stage0", chain[0], 1);
`ifdef CCFF_READBACK_EN
        check("A_rb_count", rb_n, 5);
        for (int i = 0; i < 4; i++) begin
            check("A_rb_word_ff", rb_vals[i], 8'hFF);
            check("A_rb_cyc", rb_cyc[i], 10 + 9 * i);
        end
        check("A_rb_last", rb_vals[4], 8'h01);
        check("A_rb_last_cyc", rb_cyc[4], 39);
`else
        check("A_rb_none", rb_n, 0);
        check("A_rb_data_zero", cif.rb_data, 0);
`endif

        // Pass B: valid dropped for 5 cycles in LOAD before the 3rd word
        run_pass(2, 5, -1, -1);
        check("B_hs2", hs_cyc[2], 24);
        check("B_hs4", hs_cyc[4], 42);
        check("B_shifts", n_shift, 33);
        check("B_done_cyc", done_cyc, 44);
        check("B_gap_quiet", gap_bad, 0);
        check("B_chain", chain, exp_chain);

        // Pass C: cfg_start pulsed during SHIFT is ignored
        run_pass(99, 0, 5, -1);
        check("C_hs3", hs_cyc[3], 28);
        check("C_shifts", n_shift, 33);
        check("C_done_cyc", done_cyc, 39);
        check("C_chain", chain, exp_chain);

        // Pass D: reset at cycle 15, then a fresh full pass
        run_pass(99, 0, -1, 15);
        repeat (2) @(posedge prog_clk);
        #1;
        prog_reset_n = 1'b1;
        check("D_after_rst_ready", cif.cfg_ready, 0);
        run_pass(99, 0, -1, -1);
        check("E_shifts", n_shift, 33);
        check("E_done_cyc", done_cyc, 39);
        check("E_chain", chain, exp_chain);

        // Single-word chain: CHAIN_LEN = WORD_W = 8
        hs8 = -1; n_shift8 = 0; done8 = -1;
        for (int cyc = 0; cyc < 40 && done8 < 0; cyc++) begin
            @(posedge prog_clk); #1;
            cif8.cfg_start = (cyc == 0);
            cif8.cfg_valid = 1'b1;
            cif8.cfg_data  = 8'h96;
            if (sh8) n_shift8++;
            if (cif8.cfg_done) done8 = cyc;
            if (cif8.cfg_ready && hs8 < 0) hs8 = cyc;
        end
        cif8.cfg_valid = 1'b0;
        check("L8_hs", hs8, 1);
        check("L8_shifts", n_shift8, 8);
        check("L8_done_cyc", done8, 10);
        check("L8_chain", chain8, 8'h96);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
